// File: rtl/sm3_kdf_top.sv
// SM2 key-derivation engine streaming Hash(Z || ct) words over valid/ready,
// together with the iterative two-block SM3 compression core it drives.

module sm3_1024_processing (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [1023:0] datain,
  output logic [255:0]  hashout,
  output logic          valid
);
  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  logic         busy_q, busy_d;
  logic         blk_q, blk_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [255:0] v_q, v_d;
  logic [255:0] abcd_q, abcd_d;
  logic [255:0] hash_q, hash_d;
  logic [511:0] w_q, w_d;
  logic [511:0] blk2_q, blk2_d;
  logic         valid_q, valid_d;

  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  w_j, w_jp, w_new, tj, ff, gg, ss1, ss2, tt1, tt2;
  logic         early;
  logic [255:0] abcd_nxt, v_nxt;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  // One compression round per cycle; w_q is a sliding window with W[j] in the top word.
  always_comb begin
    {a, b, c, d, e, f, g, h} = abcd_q;
    early = (rnd_q[5:4] == 2'b00);
    w_j   = w_q[511:480];
    w_jp  = w_j ^ w_q[383:352];
    w_new = p1(w_j ^ w_q[287:256] ^ rotl(w_q[95:64], 5'd15))
            ^ rotl(w_q[415:384], 5'd7) ^ w_q[191:160];
    tj    = early ? 32'h79cc4519 : 32'h7a879d8a;
    ff    = early ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg    = early ? (e ^ f ^ g) : ((e & f) | (~e & g));
    ss1   = rotl(rotl(a, 5'd12) + e + rotl(tj, rnd_q[4:0]), 5'd7);
    ss2   = ss1 ^ rotl(a, 5'd12);
    tt1   = ff + d + ss2 + w_jp;
    tt2   = gg + h + ss1 + w_j;
    abcd_nxt = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
    v_nxt    = abcd_nxt ^ v_q;
  end

  always_comb begin
    busy_d  = busy_q;
    blk_d   = blk_q;
    rnd_d   = rnd_q;
    v_d     = v_q;
    abcd_d  = abcd_q;
    hash_d  = hash_q;
    w_d     = w_q;
    blk2_d  = blk2_q;
    valid_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        blk_d  = 1'b0;
        rnd_d  = 6'd0;
        v_d    = IV;
        abcd_d = IV;
        w_d    = datain[1023:512];
        blk2_d = datain[511:0];
      end
    end else begin
      abcd_d = abcd_nxt;
      w_d    = {w_q[479:0], w_new};
      rnd_d  = rnd_q + 6'd1;
      if (rnd_q == 6'd63) begin
        if (!blk_q) begin
          blk_d  = 1'b1;
          v_d    = v_nxt;
          abcd_d = v_nxt;
          w_d    = blk2_q;
        end else begin
          busy_d  = 1'b0;
          hash_d  = v_nxt;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q  <= 1'b0;
      blk_q   <= 1'b0;
      rnd_q   <= 6'd0;
      v_q     <= '0;
      abcd_q  <= '0;
      hash_q  <= '0;
      w_q     <= '0;
      blk2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      blk_q   <= blk_d;
      rnd_q   <= rnd_d;
      v_q     <= v_d;
      abcd_q  <= abcd_d;
      hash_q  <= hash_d;
      w_q     <= w_d;
      blk2_q  <= blk2_d;
      valid_q <= valid_d;
    end
  end

  assign hashout = hash_q;
  assign valid   = valid_q;
endmodule

module sm3_kdf_top #(
  parameter int ZWIDTH = 512,
  parameter int KLEN_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ZWIDTH-1:0] z_in,
  input  logic [KLEN_W-1:0] klen_in,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic [255:0]      kout,
  output logic              kout_valid,
  input  logic              kout_ready,
  output logic              kout_last,
  output logic [8:0]        kout_nbits,
  output logic              done,
  output logic              zero_flag
);
  localparam int          PADW    = 1024 - ZWIDTH - 97;
  localparam logic [63:0] MSG_LEN = 64'(ZWIDTH + 32);

  typedef enum logic [2:0] {IDLE, LOAD, PROC, OUT, FIN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ZWIDTH-1:0]   z_q, z_d;
  logic [KLEN_W-1:0]   rem_q, rem_d;
  logic [31:0]         ct_q, ct_d;
  logic                nz_q, nz_d;
  logic [255:0]        kout_q, kout_d;
  logic                last_q, last_d;
  logic [8:0]          nbits_q, nbits_d;
  logic                zero_flag_q, zero_flag_d;

  logic                core_start, core_valid;
  logic [255:0]        core_hash, mask, masked;
  logic [1023:0]       hashdata;
  logic                cur_last;
  logic [8:0]          cur_nbits;

  assign hashdata = {z_q, ct_q, 1'b1, {PADW{1'b0}}, MSG_LEN};

  sm3_1024_processing u_core (
    .clk     (clk),
    .rstn    (rstn),
    .start   (core_start),
    .datain  (hashdata),
    .hashout (core_hash),
    .valid   (core_valid)
  );

  // rem_q holds the bits still to be delivered, so the word in flight is last once it fits.
  always_comb begin
    cur_last  = (rem_q <= KLEN_W'(256));
    cur_nbits = cur_last ? rem_q[8:0] : 9'd256;
    mask      = ~({256{1'b1}} >> cur_nbits);
    masked    = core_hash & mask;
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    rem_d       = rem_q;
    ct_d        = ct_q;
    nz_d        = nz_q;
    kout_d      = kout_q;
    last_d      = last_q;
    nbits_d     = nbits_q;
    zero_flag_d = zero_flag_q;
    core_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          zero_flag_d = 1'b0;
          nz_d        = 1'b0;
          ct_d        = 32'd1;
          if (klen_in == '0) begin
            zero_flag_d = 1'b1;
            state_d     = FIN;
          end else begin
            z_d     = z_in;
            rem_d   = klen_in;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        core_start = 1'b1;
        state_d    = abort ? DRAIN : PROC;
      end
      PROC: begin
        if (abort) begin
          zero_flag_d = 1'b0;
          state_d     = core_valid ? IDLE : DRAIN;
        end else if (core_valid) begin
          kout_d  = masked;
          last_d  = cur_last;
          nbits_d = cur_nbits;
          nz_d    = nz_q | (|masked);
          state_d = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          zero_flag_d = 1'b0;
          state_d     = IDLE;
        end else if (kout_ready) begin
          if (last_q) begin
            zero_flag_d = ~nz_q;
            state_d     = FIN;
          end else begin
            ct_d    = ct_q + 32'd1;
            rem_d   = rem_q - KLEN_W'(256);
            state_d = LOAD;
          end
        end
      end
      FIN:     state_d = IDLE;
      DRAIN:   if (core_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      z_q         <= '0;
      rem_q       <= '0;
      ct_q        <= 32'd1;
      nz_q        <= 1'b0;
      kout_q      <= '0;
      last_q      <= 1'b0;
      nbits_q     <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      rem_q       <= rem_d;
      ct_q        <= ct_d;
      nz_q        <= nz_d;
      kout_q      <= kout_d;
      last_q      <= last_d;
      nbits_q     <= nbits_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign kout_valid = (state_q == OUT);
  assign done       = (state_q == FIN);
  assign kout       = kout_q;
  assign kout_last  = last_q;
  assign kout_nbits = nbits_q;
  assign zero_flag  = zero_flag_q;
endmodule
